// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per W_MI request over a
// req/ack handshake, latches it into IR and exposes the decoded fields.
module fetch_unit #(
   parameter int              AW       = 16,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter int              TIMEOUT  = 15
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          W_MI,
   input  logic          W_PC,
   input  logic          S_MXPC,
   input  logic [AW-1:0] BR_ADDR,
   output logic [AW-1:0] IM_ADDR,
   output logic          IM_REQ,
   input  logic          IM_ACK,
   input  logic [31:0]   IM_DATA,
   output logic [AW-1:0] PC,
   output logic [31:0]   IR,
   output logic [2:0]    itype,
   output logic [4:0]    op,
   output logic [4:0]    rd,
   output logic [4:0]    ra,
   output logic [4:0]    rb,
   output logic [15:0]   imm,
   output logic          FETCH_BUSY,
   output logic          FETCH_DONE,
   output logic          FETCH_ERR
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] im_addr_q, im_addr_d;
   logic [31:0]   ir_q, ir_d;
   logic          im_req_q, im_req_d;
   logic          err_q, err_d;
   logic [7:0]    cnt_q, cnt_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         im_addr_q <= '0;
         ir_q      <= '0;
         im_req_q  <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         im_addr_q <= im_addr_d;
         ir_q      <= ir_d;
         im_req_q  <= im_req_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      im_addr_d = im_addr_q;
      ir_d      = ir_q;
      im_req_d  = im_req_q;
      err_d     = err_q;
      cnt_d     = cnt_q;

      // PC updates in every state; an in-flight fetch keeps its latched address.
      if (W_PC) begin
         pc_d = S_MXPC ? BR_ADDR : pc_q + AW'(1);
      end

      case (state_q)
         IDLE: begin
            if (W_MI) begin
               im_addr_d = pc_q;
               im_req_d  = 1'b1;
               cnt_d     = '0;
               err_d     = 1'b0;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (IM_ACK) begin
               ir_d     = IM_DATA;
               im_req_d = 1'b0;
               state_d  = DONE;
            end else if (cnt_q == CNT_LAST) begin
               // Timed out: hand a NOP to the control unit and flag the error.
               ir_d     = '0;
               im_req_d = 1'b0;
               err_d    = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign PC         = pc_q;
   assign IR         = ir_q;
   assign IM_ADDR    = im_addr_q;
   assign IM_REQ     = im_req_q;
   assign FETCH_ERR  = err_q;
   assign FETCH_BUSY = (state_q == REQ);
   assign FETCH_DONE = (state_q == DONE);

   assign itype = ir_q[31:29];
   assign op    = ir_q[28:24];
   assign rd    = ir_q[23:19];
   assign ra    = ir_q[18:14];
   assign rb    = ir_q[13:9];
   assign imm   = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, handshake timing, timeout,
// PC wrap/branch and reset abort, with hand-computed expected values.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        W_MI, W_PC, S_MXPC, IM_ACK;
   logic [15:0] BR_ADDR;
   logic [31:0] IM_DATA;
   logic [15:0] IM_ADDR, PC;
   logic        IM_REQ;
   logic [31:0] IR;
   logic [2:0]  itype;
   logic [4:0]  op, rd, ra, rb;
   logic [15:0] imm;
   logic        FETCH_BUSY, FETCH_DONE, FETCH_ERR;

   int checks = 0;
   int errors = 0;

   fetch_unit #(
      .AW       (16),
      .RESET_PC (16'h0010),
      .TIMEOUT  (15)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .W_MI       (W_MI),
      .W_PC       (W_PC),
      .S_MXPC     (S_MXPC),
      .BR_ADDR    (BR_ADDR),
      .IM_ADDR    (IM_ADDR),
      .IM_REQ     (IM_REQ),
      .IM_ACK     (IM_ACK),
      .IM_DATA    (IM_DATA),
      .PC         (PC),
      .IR         (IR),
      .itype      (itype),
      .op         (op),
      .rd         (rd),
      .ra         (ra),
      .rb         (rb),
      .imm        (imm),
      .FETCH_BUSY (FETCH_BUSY),
      .FETCH_DONE (FETCH_DONE),
      .FETCH_ERR  (FETCH_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      RST = 1'b1; W_MI = 1'b0; W_PC = 1'b0; S_MXPC = 1'b0; IM_ACK = 1'b0;
      BR_ADDR = '0; IM_DATA = '0;

      // Reset held for two cycles
      tick(); tick();
      check_output("rst_pc",     32'(PC),         32'h0010);
      check_output("rst_ir",     IR,              32'h0);
      check_output("rst_req",    32'(IM_REQ),     32'h0);
      check_output("rst_addr",   32'(IM_ADDR),    32'h0);
      check_output("rst_err",    32'(FETCH_ERR),  32'h0);
      check_output("rst_busy",   32'(FETCH_BUSY), 32'h0);
      check_output("rst_done",   32'(FETCH_DONE), 32'h0);
      RST = 1'b0;

      // Fastest fetch: ack on the first cycle of the request
      W_MI = 1'b1;
      tick();
      W_MI = 1'b0;
      check_output("f1_req",     32'(IM_REQ),     32'h1);
      check_output("f1_busy",    32'(FETCH_BUSY), 32'h1);
      check_output("f1_addr",    32'(IM_ADDR),    32'h0010);
      check_output("f1_ir_hold", IR,              32'h0);
      IM_ACK = 1'b1; IM_DATA = 32'h2A4C_8123;
      tick();
      IM_ACK = 1'b0;
      check_output("f1_ir",      IR,              32'h2A4C_8123);
      check_output("f1_type",    32'(itype),      32'h1);
      check_output("f1_op",      32'(op),         32'h0A);
      check_output("f1_rd",      32'(rd),         32'h09);
      check_output("f1_ra",      32'(ra),         32'h12);
      check_output("f1_rb",      32'(rb),         32'h00);
      check_output("f1_imm",     32'(imm),        32'h8123);
      check_output("f1_done",    32'(FETCH_DONE), 32'h1);
      check_output("f1_req_lo",  32'(IM_REQ),     32'h0);
      tick();
      check_output("f1_done_lo", 32'(FETCH_DONE), 32'h0);
      check_output("f1_busy_lo", 32'(FETCH_BUSY), 32'h0);

      // Three wait cycles, with a PC increment while the request is pending
      W_MI = 1'b1;
      tick();
      W_MI = 1'b0;
      check_output("f2_req0",    32'(IM_REQ),     32'h1);
      for (int i = 0; i < 3; i++) begin
         W_PC = (i == 1);
         tick();
         check_output("f2_req_w",  32'(IM_REQ),     32'h1);
         check_output("f2_busy_w", 32'(FETCH_BUSY), 32'h1);
         check_output("f2_addr_w", 32'(IM_ADDR),    32'h0010);
      end
      W_PC = 1'b0;
      check_output("f2_pc_inc",  32'(PC),         32'h0011);
      IM_ACK = 1'b1; IM_DATA = 32'hDEAD_BEEF;
      tick();
      IM_ACK = 1'b0;
      check_output("f2_ir",      IR,              32'hDEAD_BEEF);
      check_output("f2_done",    32'(FETCH_DONE), 32'h1);
      check_output("f2_req_lo",  32'(IM_REQ),     32'h0);
      // W_MI during DONE must be ignored
      W_MI = 1'b1;
      tick();
      W_MI = 1'b0;
      check_output("f2_done_wmi", 32'(IM_REQ),    32'h0);
      check_output("f2_idle",     32'(FETCH_BUSY), 32'h0);

      // No ack: timeout after 15 request cycles
      W_MI = 1'b1;
      tick();
      W_MI = 1'b0;
      check_output("to_addr",    32'(IM_ADDR),    32'h0011);
      for (int i = 0; i < 14; i++) begin
         tick();
         check_output("to_req_w",  32'(IM_REQ),     32'h1);
         check_output("to_done_w", 32'(FETCH_DONE), 32'h0);
      end
      tick();
      check_output("to_ir",      IR,              32'h0);
      check_output("to_err",     32'(FETCH_ERR),  32'h1);
      check_output("to_done",    32'(FETCH_DONE), 32'h1);
      check_output("to_req_lo",  32'(IM_REQ),     32'h0);
      tick();
      check_output("to_err_sticky", 32'(FETCH_ERR), 32'h1);
      // Stray ack in IDLE must not touch IR or state
      IM_ACK = 1'b1; IM_DATA = 32'h1234_5678;
      tick();
      IM_ACK = 1'b0;
      check_output("stray_ir",   IR,              32'h0);
      check_output("stray_busy", 32'(FETCH_BUSY), 32'h0);
      check_output("stray_done", 32'(FETCH_DONE), 32'h0);
      W_MI = 1'b1;
      tick();
      W_MI = 1'b0;
      check_output("err_clear",  32'(FETCH_ERR),  32'h0);
      IM_ACK = 1'b1; IM_DATA = 32'h0123_4567;
      tick();
      IM_ACK = 1'b0;
      check_output("f3_ir",      IR,              32'h0123_4567);
      tick();

      // PC wrap and branch
      W_PC = 1'b1; S_MXPC = 1'b1; BR_ADDR = 16'hFFFF;
      tick();
      check_output("pc_ffff",    32'(PC),         32'hFFFF);
      S_MXPC = 1'b0;
      tick();
      check_output("pc_wrap",    32'(PC),         32'h0000);
      S_MXPC = 1'b1; BR_ADDR = 16'h1234;
      tick();
      check_output("pc_branch",  32'(PC),         32'h1234);
      W_PC = 1'b0; S_MXPC = 1'b0;
      tick();
      check_output("pc_hold",    32'(PC),         32'h1234);

      // W_MI and W_PC together: fetch uses the old PC
      W_MI = 1'b1; W_PC = 1'b1;
      tick();
      W_MI = 1'b0; W_PC = 1'b0;
      check_output("same_addr",  32'(IM_ADDR),    32'h1234);
      check_output("same_pc",    32'(PC),         32'h1235);

      // Reset in the middle of a request, late ack afterwards
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check_output("abort_pc",   32'(PC),         32'h0010);
      check_output("abort_ir",   IR,              32'h0);
      check_output("abort_req",  32'(IM_REQ),     32'h0);
      IM_ACK = 1'b1; IM_DATA = 32'hFFFF_FFFF;
      tick();
      IM_ACK = 1'b0;
      check_output("late_ir",    IR,              32'h0);
      check_output("late_busy",  32'(FETCH_BUSY), 32'h0);
      check_output("late_done",  32'(FETCH_DONE), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
